sm2u2_serial: RTL
=================

SM2U2_SERIAL -- requirements
Module: sm2u2_serial

Interface
REQ-001 Parameter: NUM, default 4, word width in bits; legal range NUM >= 2.
REQ-002 Port: i_clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: i_rst  input  1  reset, synchronous, active-high.
REQ-004 Port: i_valid  input  1  input word present on i_argA.
REQ-005 Port: o_ready  output  1  block can accept a word (IDLE only).
REQ-006 Port: i_argA  input  NUM  sign-magnitude operand; bit NUM-1 = sign, bits NUM-2..0 = magnitude.
REQ-007 Port: o_valid  output  1  o_result holds a completed conversion.
REQ-008 Port: i_ready  input  1  downstream accepts o_result.
REQ-009 Port: o_result  output  NUM  two's-complement (U2) result, signed.
REQ-010 Port: o_negzero  output  1  completed input was minus zero (sign=1, magnitude=0); qualified by o_valid.

Function
REQ-011 The block SHALL convert a sign-magnitude word to U2, bit-serially, one magnitude bit per clock.
REQ-012 The FSM SHALL have states IDLE, CONV, DONE, with no other reachable states.
REQ-013 IDLE: o_ready=1, o_valid=0; on i_valid=1 the block SHALL capture i_argA into a shift register, clear the bit counter and the seen-one flag, and go to CONV.
REQ-014 CONV: o_ready=0, o_valid=0; each edge processes magnitude bit k (k = 0..NUM-2, LSB first).
REQ-015 Sign=0: each processed bit SHALL be copied unchanged.
REQ-016 Sign=1: each bit SHALL be copied up to and including the first 1; every later bit SHALL be inverted.
REQ-017 CONV SHALL last exactly NUM-1 edges regardless of operand value, then go to DONE.
REQ-018 Result MSB SHALL be 1 iff sign=1 and magnitude != 0; otherwise 0.
REQ-019 Minus zero (sign=1, magnitude=0) SHALL produce o_result=0 and o_negzero=1.
REQ-020 o_negzero SHALL be 0 for every other input.
REQ-021 Latency: o_valid SHALL rise NUM-1 edges after the accepting edge (NUM=4: 3 edges).
REQ-022 DONE: o_valid=1, o_ready=0; o_result and o_negzero SHALL stay stable until i_ready=1.
REQ-023 DONE with i_ready=1 SHALL complete the transfer and return to IDLE on that edge.
REQ-024 Throughput SHALL be at most one word per NUM+1 cycles; no back-to-back accept from DONE.
REQ-025 i_valid and i_argA SHALL be ignored outside IDLE; no queuing.
REQ-026 i_ready SHALL be ignored outside DONE.
REQ-027 o_result and o_negzero SHALL be registered and update only on entry to DONE; they hold the last result otherwise.
REQ-028 Bit counter width SHALL be $clog2(NUM); the counter SHALL NOT wrap within one conversion.

Reset
REQ-029 On i_rst=1 at an edge: state=IDLE, o_ready=1, o_valid=0, o_result=0, o_negzero=0, counter=0, seen-one flag=0.
REQ-030 i_rst SHALL take priority over all handshakes.
REQ-031 Reset in CONV or DONE SHALL discard the word in flight; no o_valid for it.
REQ-032 Asserting i_rst together with i_valid SHALL NOT accept the word.

Verification (NUM=4)
REQ-033 i_argA=0101, i_valid one cycle -> o_valid 3 edges later, o_result=0101, o_negzero=0.
REQ-034 i_argA=1011 (-3) -> o_result=1101; i_argA=1110 (-6) -> 1010; i_argA=1111 (-7) -> 1001.
REQ-035 i_argA=1000 -> o_result=0000, o_negzero=1.
REQ-036 Hold i_ready=0 for 5 cycles in DONE -> o_valid, o_result and o_negzero stable; i_ready=1 -> IDLE next cycle, o_ready=1.
REQ-037 Pulse i_valid with a new word during CONV -> word ignored; result matches the first word only.
REQ-038 Assert i_rst on the 2nd CONV edge -> IDLE, o_valid stays 0, no result delivered; next word converts correctly.

Source files
------------

// File: rtl/sm2u2_serial.sv
`default_nettype none
// ============================================================================
//  Module      : sm2u2_serial
//  Description : Bit-serial sign-magnitude to two's-complement converter.
//                One magnitude bit is processed per clock, LSB first, with a
//                valid/ready handshake on both sides.
//  Revision    : 1.0 - initial release
// ============================================================================
module sm2u2_serial #(
    parameter int NUM = 4
) (
    input  logic           i_clk,
    input  logic           i_rst,
    input  logic           i_valid,
    output logic           o_ready,
    input  logic [NUM-1:0] i_argA,
    output logic           o_valid,
    input  logic           i_ready,
    output logic [NUM-1:0] o_result,
    output logic           o_negzero
);

    localparam int              CNT_W  = $clog2(NUM);
    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(NUM - 2);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CONV = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    // Shift register: magnitude bits leave at the LSB while converted bits
    // enter at the MSB, so after NUM-1 steps it holds the result magnitude.
    logic [NUM-2:0]   r_shift;
    logic             r_sign;
    logic             r_seen;
    logic [CNT_W-1:0] r_cnt;
    logic [NUM-1:0]   r_result;
    logic             r_negzero;

    logic             w_bit;
    logic             w_seen_nxt;
    logic             w_outbit;
    logic             w_last;
    logic [NUM-2:0]   w_shift_nxt;

    assign w_bit      = r_shift[0];
    assign w_seen_nxt = r_seen | w_bit;
    // Negative operands invert every bit strictly after the first one.
    assign w_outbit   = w_bit ^ (r_sign & r_seen);
    assign w_last     = (r_cnt == c_LAST);

    generate
        if (NUM > 2) begin : g_shift_wide
            assign w_shift_nxt = {w_outbit, r_shift[NUM-2:1]};
        end else begin : g_shift_narrow
            assign w_shift_nxt = w_outbit;
        end
    endgenerate

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        w_state_nxt = r_state;
        o_ready     = 1'b0;
        o_valid     = 1'b0;
        case (r_state)
            S_IDLE: begin
                o_ready = 1'b1;
                if (i_valid) begin
                    w_state_nxt = S_CONV;
                end
            end
            S_CONV: begin
                if (w_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                o_valid = 1'b1;
                if (i_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Datapath: capture, serial conversion, and result registers loaded on DONE entry.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_shift   <= '0;
            r_sign    <= 1'b0;
            r_seen    <= 1'b0;
            r_cnt     <= '0;
            r_result  <= '0;
            r_negzero <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_valid) begin
                        r_shift <= i_argA[NUM-2:0];
                        r_sign  <= i_argA[NUM-1];
                        r_seen  <= 1'b0;
                        r_cnt   <= '0;
                    end
                end
                S_CONV: begin
                    r_shift <= w_shift_nxt;
                    r_seen  <= w_seen_nxt;
                    if (w_last) begin
                        // Minus zero never sees a 1, so it yields +0 with the flag set.
                        r_result  <= {r_sign & w_seen_nxt, w_shift_nxt};
                        r_negzero <= r_sign & ~w_seen_nxt;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign o_result  = r_result;
    assign o_negzero = r_negzero;

endmodule
`default_nettype wire
